// File: rtl/board_pkg.sv
// Shared types and constants for the 2048 board engine: direction codes,
// exponent limits, FSM states, LFSR taps and the line-to-cell index map.
package board_pkg;

    localparam int EXP_W = 4;
    localparam logic [EXP_W-1:0] WIN_EXP = 4'd11;
    localparam logic [EXP_W-1:0] MAX_EXP = 4'd15;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Fibonacci taps 16,14,13,11 (bit n-1 for tap n)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [EXP_W-1:0] exp_t;
    typedef exp_t [3:0] line_t;
    typedef exp_t [15:0] board_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SPAWN = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    // Element 0 of every line sits against the wall the tiles slide toward.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir,
                                            input logic [1:0] line,
                                            input logic [1:0] elem);
        case (dir)
            DIR_LEFT:  cell_idx = {line, elem};
            DIR_RIGHT: cell_idx = {line, 2'd3 - elem};
            DIR_UP:    cell_idx = {elem, line};
            DIR_DOWN:  cell_idx = {2'd3 - elem, line};
            default:   cell_idx = {line, elem};
        endcase
    endfunction

    function automatic logic [16:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = {1'b0, cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/board_engine_if.sv
// Move/load/render bus between the input controller, row renderers and the engine.
interface board_engine_if;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        load_valid;
    logic [3:0]  load_addr;
    logic [3:0]  load_exp;
    logic [1:0]  rd_row;
    logic [1:0]  rd_col;
    logic [16:0] rd_data;

    modport master (output move_valid, move_dir, load_valid, load_addr, load_exp,
                    rd_row, rd_col, input move_ready, rd_data);
    modport slave  (input move_valid, move_dir, load_valid, load_addr, load_exp,
                    rd_row, rd_col, output move_ready, rd_data);
endinterface

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one 4-cell line toward element 0.
module line_merge
    import board_pkg::*;
(
    input  line_t       in_line,
    output line_t       out_line,
    output logic        changed,
    output logic [16:0] score_inc
);

    line_t      comp_s;
    logic [3:0] pair_s;

    // Compact non-zero cells, then merge left-to-right with each result merging once
    always_comb begin
        logic [2:0] k;
        logic       skip;
        comp_s    = '0;
        out_line  = '0;
        score_inc = 17'd0;
        pair_s    = 4'd0;
        k         = 3'd0;
        skip      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (in_line[i] != 4'd0) begin
                comp_s[k[1:0]] = in_line[i];
                k = k + 3'd1;
            end else begin
                k = k;
            end
        end
        for (int i = 0; i < 3; i++) begin
            pair_s[i] = (comp_s[i] != 4'd0) && (comp_s[i] == comp_s[i+1]) &&
                        (comp_s[i] != MAX_EXP);
        end
        k = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (pair_s[i]) begin
                out_line[k[1:0]] = comp_s[i] + 4'd1;
                score_inc = score_inc + (17'd1 << (comp_s[i] + 4'd1));
                k = k + 3'd1;
                skip = 1'b1;
            end else begin
                out_line[k[1:0]] = comp_s[i];
                k = k + 3'd1;
            end
        end
        changed = (out_line != in_line);
    end

endmodule

// File: rtl/board_engine.sv
// 2048 game-state engine: board storage, move FSM, tile spawning, score,
// win/game-over tracking and the registered render read port.
module board_engine
    import board_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic            CLK100MHZ,
    input  logic            reset,
    board_engine_if.slave   bus,
    output logic [19:0]     score,
    output logic            win,
    output logic            game_over
);

    state_t      state_q, state_d;
    board_t      board_q, board_d;
    logic [1:0]  line_q, line_d;
    logic [1:0]  dir_q, dir_d;
    logic        changed_q, changed_d;
    logic [3:0]  spawn_idx_q, spawn_idx_d;
    logic        spawn_first_q, spawn_first_d;
    logic        init_cnt_q, init_cnt_d;
    logic        eval_q, eval_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [19:0] score_q, score_d;
    logic        win_q, win_d;
    logic        game_over_q, game_over_d;
    logic        move_ready_q, move_ready_d;
    logic [16:0] rd_data_q, rd_data_d;

    line_t       line_in_s, line_out_s;
    logic        line_changed_s;
    logic [16:0] score_inc_s;
    logic [20:0] score_sum_s;
    logic        full_s, pair_s, big_s, line_big_s;
    logic [3:0]  spawn_pos_s;
    logic        spawn_hit_s;
    exp_t        spawn_exp_s;
    logic [16:0] lfsr_n_s;
    exp_t        rd_exp_s;

    line_merge u_merge (
        .in_line   (line_in_s),
        .out_line  (line_out_s),
        .changed   (line_changed_s),
        .score_inc (score_inc_s)
    );

    // Board-wide status: empty cells, mergeable neighbours, winning tile
    always_comb begin
        full_s = 1'b1;
        pair_s = 1'b0;
        big_s  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (board_q[i] == 4'd0) full_s = 1'b0; else full_s = full_s;
            if (board_q[i] >= WIN_EXP) big_s = 1'b1; else big_s = big_s;
        end
        for (int i = 0; i < 15; i++) begin
            if ((i % 4 != 3) && (board_q[i] == board_q[i+1])) pair_s = 1'b1;
            else pair_s = pair_s;
        end
        for (int i = 0; i < 12; i++) begin
            if (board_q[i] == board_q[i+4]) pair_s = 1'b1; else pair_s = pair_s;
        end
    end

    // Line routing for the time-multiplexed merge unit, plus spawn candidate
    always_comb begin
        line_big_s = 1'b0;
        for (int j = 0; j < 4; j++) begin
            line_in_s[j] = board_q[cell_idx(dir_q, line_q, 2'(j))];
            if (line_out_s[j] >= WIN_EXP) line_big_s = 1'b1; else line_big_s = line_big_s;
        end
        spawn_pos_s = spawn_first_q ? lfsr_q[3:0] : spawn_idx_q;
        spawn_hit_s = (board_q[spawn_pos_s] == 4'd0);
        spawn_exp_s = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
        score_sum_s = {1'b0, score_q} + {4'd0, score_inc_s};
        lfsr_n_s    = lfsr_next(lfsr_q);
        rd_exp_s    = board_q[{bus.rd_row, bus.rd_col}];
    end

    // Next-state, board update and registered output computation
    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        line_d        = line_q;
        dir_d         = dir_q;
        changed_d     = changed_q;
        spawn_idx_d   = spawn_idx_q;
        spawn_first_d = spawn_first_q;
        init_cnt_d    = init_cnt_q;
        eval_d        = 1'b0;
        score_d       = score_q;
        win_d         = win_q;
        game_over_d   = game_over_q;
        lfsr_d        = lfsr_n_s[15:0];
        rd_data_d     = (rd_exp_s == 4'd0) ? 17'd0 : (17'd1 << rd_exp_s);

        case (state_q)
            ST_INIT, ST_SPAWN: begin
                if (spawn_hit_s) begin
                    board_d[spawn_pos_s] = spawn_exp_s;
                    spawn_first_d = 1'b1;
                    if (state_q == ST_SPAWN) begin
                        state_d = ST_CHECK;
                    end else if (init_cnt_q) begin
                        state_d    = ST_IDLE;
                        init_cnt_d = 1'b0;
                    end else begin
                        init_cnt_d = 1'b1;
                    end
                end else begin
                    spawn_idx_d   = spawn_pos_s + 4'd1;
                    spawn_first_d = 1'b0;
                end
            end
            ST_IDLE: begin
                if (eval_q) begin
                    game_over_d = full_s && !pair_s;
                    win_d       = win_q | big_s;
                end else begin
                    game_over_d = game_over_q;
                end
                if (bus.load_valid) begin
                    board_d[bus.load_addr] = bus.load_exp;
                    eval_d = 1'b1;
                end else if (bus.move_valid && move_ready_q) begin
                    state_d   = ST_SHIFT;
                    dir_d     = bus.move_dir;
                    line_d    = 2'd0;
                    changed_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                for (int j = 0; j < 4; j++) begin
                    board_d[cell_idx(dir_q, line_q, 2'(j))] = line_out_s[j];
                end
                changed_d = changed_q | line_changed_s;
                score_d   = score_sum_s[20] ? 20'hFFFFF : score_sum_s[19:0];
                win_d     = win_q | line_big_s;
                line_d    = line_q + 2'd1;
                if (line_q == 2'd3) begin
                    state_d       = changed_d ? ST_SPAWN : ST_IDLE;
                    spawn_first_d = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                game_over_d = full_s && !pair_s;
                win_d       = win_q | big_s;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // A pending post-load evaluation holds moves off for one cycle
        move_ready_d = (state_d == ST_IDLE) && !game_over_d && !eval_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q       <= ST_INIT;
            board_q       <= '0;
            line_q        <= 2'd0;
            dir_q         <= 2'd0;
            changed_q     <= 1'b0;
            spawn_idx_q   <= 4'd0;
            spawn_first_q <= 1'b1;
            init_cnt_q    <= 1'b0;
            eval_q        <= 1'b0;
            lfsr_q        <= SEED;
            score_q       <= 20'd0;
            win_q         <= 1'b0;
            game_over_q   <= 1'b0;
            move_ready_q  <= 1'b0;
            rd_data_q     <= 17'd0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            line_q        <= line_d;
            dir_q         <= dir_d;
            changed_q     <= changed_d;
            spawn_idx_q   <= spawn_idx_d;
            spawn_first_q <= spawn_first_d;
            init_cnt_q    <= init_cnt_d;
            eval_q        <= eval_d;
            lfsr_q        <= lfsr_d;
            score_q       <= score_d;
            win_q         <= win_d;
            game_over_q   <= game_over_d;
            move_ready_q  <= move_ready_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign score          = score_q;
    assign win            = win_q;
    assign game_over      = game_over_q;
    assign bus.move_ready = move_ready_q;
    assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_board_engine.sv
// Self-checking bench for board_engine: loads boards, issues moves and
// compares render reads and status outputs against hand-derived expectations.
module tb_board_engine;
    import board_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] score;
    logic        win;
    logic        game_over;
    int          total = 0;
    int          bad = 0;
    int          exp_score = 0;
    logic [16:0] sb_q[$];

    board_engine_if bus ();

    board_engine #(.SEED(16'hACE1)) dut (
        .CLK100MHZ (clk),
        .reset     (rst),
        .bus       (bus.slave),
        .score     (score),
        .win       (win),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic rd_cell(input int i, output logic [16:0] v);
        @(negedge clk);
        bus.rd_row = 2'(i / 4);
        bus.rd_col = 2'(i % 4);
        @(posedge clk);
        #1 v = bus.rd_data;
    endtask

    task automatic expect_cell(input int i, input logic [16:0] val);
        logic [16:0] v;
        logic [16:0] e;
        sb_q.push_back(val);
        rd_cell(i, v);
        e = sb_q.pop_front();
        total++;
        if (v !== e) begin
            bad++;
            $display("FAIL cell%0d: got %0d want %0d", i, v, e);
        end
    endtask

    task automatic count_tiles(input logic [15:0] skip, output int n, output int odd);
        logic [16:0] v;
        n = 0;
        odd = 0;
        for (int i = 0; i < 16; i++) begin
            if (!skip[i]) begin
                rd_cell(i, v);
                if (v != 17'd0) begin
                    n++;
                    if (v != 17'd2 && v != 17'd4) odd++;
                end
            end
        end
    endtask

    task automatic load_cell(input int addr, input int e);
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_addr  = 4'(addr);
        bus.load_exp   = 4'(e);
        @(posedge clk);
        #1 bus.load_valid = 1'b0;
    endtask

    task automatic clear_board();
        for (int i = 0; i < 16; i++) load_cell(i, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (!bus.move_ready && n < limit) begin
            @(posedge clk);
            #1 n++;
        end
        total++;
        if (!bus.move_ready) begin
            bad++;
            $display("FAIL ready_timeout: move_ready=%0b after %0d cycles want 1", bus.move_ready, n);
        end
    endtask

    task automatic do_move(input logic [1:0] d, output int n);
        int w;
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_dir   = d;
        @(posedge clk);
        #1 bus.move_valid = 1'b0;
        wait_ready(80, w);
        n = w + 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (score !== 20'd0 || win !== 1'b0 || game_over !== 1'b0 ||
            bus.move_ready !== 1'b0 || bus.rd_data !== 17'd0) begin
            bad++;
            $display("FAIL reset_vals: score=%0d win=%0b go=%0b rdy=%0b rd=%0d want all 0",
                     score, win, game_over, bus.move_ready, bus.rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n, cnt, odd;
        apply_reset();
        wait_ready(40, n);
        total++;
        if (n > 32) begin
            bad++;
            $display("FAIL init_time: got %0d cycles want <=32", n);
        end
        count_tiles(16'h0000, cnt, odd);
        total++;
        if (cnt !== 2 || odd !== 0) begin
            bad++;
            $display("FAIL init_tiles: got %0d tiles (%0d bad values) want 2", cnt, odd);
        end
        total++;
        if (score !== 20'd0 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL init_status: score=%0d go=%0b want 0 0", score, game_over);
        end
    endtask

    task automatic test_merge_left();
        int n, cnt, odd;
        clear_board();
        for (int c = 0; c < 4; c++) load_cell(c, 1);
        repeat (2) @(posedge clk);
        do_move(DIR_LEFT, n);
        exp_score += 8;
        expect_cell(0, 17'd4);
        expect_cell(1, 17'd4);
        count_tiles(16'h0003, cnt, odd);
        total++;
        if (cnt !== 1 || odd !== 0) begin
            bad++;
            $display("FAIL left_spawn: got %0d new tiles (%0d bad) want 1", cnt, odd);
        end
        total++;
        if (score !== 20'(exp_score) || win !== 1'b0) begin
            bad++;
            $display("FAIL left_score: score=%0d win=%0b want %0d 0", score, win, exp_score);
        end
    endtask

    task automatic test_merge_rules();
        int n;
        clear_board();
        load_cell(4, 1);
        load_cell(5, 1);
        load_cell(6, 2);
        repeat (2) @(posedge clk);
        do_move(DIR_LEFT, n);
        exp_score += 4;
        expect_cell(4, 17'd4);
        expect_cell(5, 17'd4);
        total++;
        if (score !== 20'(exp_score)) begin
            bad++;
            $display("FAIL rules_score: got %0d want %0d", score, exp_score);
        end
    endtask

    task automatic test_noop_right();
        int n;
        clear_board();
        load_cell(3, 1);
        repeat (2) @(posedge clk);
        do_move(DIR_RIGHT, n);
        total++;
        if (n !== 5) begin
            bad++;
            $display("FAIL noop_latency: got %0d cycles want 5", n);
        end
        for (int i = 0; i < 16; i++) expect_cell(i, (i == 3) ? 17'd2 : 17'd0);
        total++;
        if (score !== 20'(exp_score)) begin
            bad++;
            $display("FAIL noop_score: got %0d want %0d", score, exp_score);
        end
    endtask

    task automatic test_win_up();
        int n, cnt, odd;
        clear_board();
        load_cell(2, 10);
        load_cell(6, 10);
        repeat (2) @(posedge clk);
        do_move(DIR_UP, n);
        exp_score += 2048;
        expect_cell(2, 17'd2048);
        count_tiles(16'h0004, cnt, odd);
        total++;
        if (cnt !== 1 || odd !== 0) begin
            bad++;
            $display("FAIL up_spawn: got %0d new tiles (%0d bad) want 1", cnt, odd);
        end
        total++;
        if (win !== 1'b1 || score !== 20'(exp_score)) begin
            bad++;
            $display("FAIL up_win: win=%0b score=%0d want 1 %0d", win, score, exp_score);
        end
    endtask

    task automatic test_max_exp();
        int n;
        clear_board();
        load_cell(0, 15);
        load_cell(1, 15);
        repeat (2) @(posedge clk);
        do_move(DIR_LEFT, n);
        total++;
        if (n !== 5) begin
            bad++;
            $display("FAIL max_noop: got %0d cycles want 5", n);
        end
        expect_cell(0, 17'd32768);
        expect_cell(1, 17'd32768);
        expect_cell(2, 17'd0);
    endtask

    task automatic test_load_vs_move();
        clear_board();
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_addr  = 4'd0;
        bus.load_exp   = 4'd1;
        bus.move_valid = 1'b1;
        bus.move_dir   = DIR_RIGHT;
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.move_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.move_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_wins_ready: got %0b want 1", bus.move_ready);
        end
        expect_cell(0, 17'd2);
        expect_cell(3, 17'd0);
    endtask

    task automatic test_game_over();
        clear_board();
        for (int i = 0; i < 16; i++) load_cell(i, (((i / 4) + (i % 4)) % 2 == 1) ? 2 : 1);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (game_over !== 1'b1 || bus.move_ready !== 1'b0) begin
            bad++;
            $display("FAIL game_over: go=%0b rdy=%0b want 1 0", game_over, bus.move_ready);
        end
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_dir   = DIR_LEFT;
        repeat (6) @(posedge clk);
        #1 bus.move_valid = 1'b0;
        expect_cell(0, 17'd2);
        expect_cell(1, 17'd4);
        expect_cell(15, 17'd2);
        total++;
        if (score !== 20'(exp_score) || bus.move_ready !== 1'b0) begin
            bad++;
            $display("FAIL go_ignored: score=%0d rdy=%0b want %0d 0", score, bus.move_ready, exp_score);
        end
    endtask

    task automatic test_reset_mid_move();
        int n, cnt, odd;
        apply_reset();
        wait_ready(40, n);
        clear_board();
        load_cell(0, 3);
        load_cell(1, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_dir   = DIR_LEFT;
        @(posedge clk);
        #1 bus.move_valid = 1'b0;
        @(posedge clk);
        apply_reset();
        exp_score = 0;
        wait_ready(40, n);
        count_tiles(16'h0000, cnt, odd);
        total++;
        if (cnt !== 2 || odd !== 0) begin
            bad++;
            $display("FAIL midreset_tiles: got %0d tiles (%0d bad) want 2", cnt, odd);
        end
        total++;
        if (score !== 20'd0 || win !== 1'b0 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL midreset_status: score=%0d win=%0b go=%0b want 0 0 0", score, win, game_over);
        end
    endtask

    initial begin
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        bus.load_valid = 1'b0;
        bus.load_addr  = 4'd0;
        bus.load_exp   = 4'd0;
        bus.rd_row     = 2'd0;
        bus.rd_col     = 2'd0;
        test_reset();
        test_merge_left();
        test_merge_rules();
        test_noop_right();
        test_win_up();
        test_max_exp();
        test_load_vs_move();
        test_game_over();
        test_reset_mid_move();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_engine.md
# board_engine

Game-state engine for 2048: holds the 4x4 tile board, executes slide/merge moves from the input controller, spawns new tiles, and tracks score, win and game-over. It is the producer side of the tile-render interface. Each row renderer supplies a row index and a column position, and this block returns the 17-bit tile value the renderer maps to a colour.

## Interface
Parameters:
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- CLK100MHZ  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- move_valid  in  1  move request.
- move_dir  in  2  direction: 0 up, 1 down, 2 left, 3 right.
- move_ready  out  1  engine idle and able to accept a move.
- load_valid  in  1  debug/bench tile write; honoured only in IDLE.
- load_addr  in  4  cell index, row*4+col.
- load_exp  in  4  exponent to write (0 = empty).
- rd_row  in  2  render read: row.
- rd_col  in  2  render read: column (renderer `position`).
- rd_data  out  17  tile value: 0 if empty, else 1<<exp.
- score  out  20  accumulated merge value, saturating.
- win  out  1  sticky; set when any tile has exp >= 11 (2048).
- game_over  out  1  no empty cell and no equal orthogonal neighbours.

## Operation
- Storage is 16 cells of 4-bit exponents. Cell index is row*4+col, row 0 is at the top, col 0 is at the left.
- States and transitions:
  - INIT: spawn two tiles → IDLE.
  - IDLE → SHIFT on move_valid && move_ready.
  - SHIFT: 4 cycles, one line per cycle, lines 0..3.
  - SHIFT → SPAWN if any line changed, else → IDLE.
  - SPAWN: 1..16 cycles → CHECK.
  - CHECK: 1 cycle → IDLE.
- Line extraction:
  - Left: row r, cols 0..3.
  - Right: row r, cols 3..0.
  - Up: col r, rows 0..3.
  - Down: col r, rows 3..0.
  - Element 0 of a line is always the wall side.
- Line merge:
  - Compact non-zero exponents toward element 0.
  - Scanning from element 0, merge an equal adjacent pair into exp+1 and clear the second cell. Each result cell merges at most once, so [1,1,1,1] → [2,2,0,0] and [1,1,2,0] → [2,2,0,0].
  - Pairs at exp 15 do not merge.
  - Each merge adds 1<<(exp+1) to score. score saturates at 20'hFFFFF.
- Line changed = output differs from input.
- SPAWN:
  - Start at candidate index lfsr[3:0].
  - If that cell is empty, write exp 1, or exp 2 when lfsr[7:4]==0, and leave SPAWN.
  - Otherwise increment the index modulo 16, one cell per cycle.
  - An empty cell is guaranteed to exist, because a changed board either merged or slid into a hole.
- INIT performs the SPAWN procedure twice.
- LFSR is 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle, including during reset release.
- CHECK: game_over <= no empty cell && no equal horizontal or vertical neighbour. win is updated whenever a cell is written.
- move_ready = (state==IDLE) && !game_over. Requests while move_ready is low are ignored, not queued.
- load_valid in IDLE writes the cell, then re-evaluates win and game_over on the next cycle. It does not spawn or score.
- load_valid and move_valid asserted in the same IDLE cycle: the load wins, and the move is not accepted that cycle.

## Timing
- Reset values:
  - Board all 0.
  - score 0, win 0, game_over 0, rd_data 0.
  - move_ready 0.
  - LFSR = SEED.
  - State = INIT.
- Reset asserted mid-move aborts the move immediately. There is no partial score carry-over.
- rd_data is registered, 1-cycle latency from rd_row/rd_col. It reflects the board contents after the previous edge.
- During SHIFT, reads may return a partially updated board, which is acceptable for display.
- Move latency from acceptance to move_ready high:
  - No-op move: 4 SHIFT cycles + 1.
  - Changed move: 4 SHIFT + k SPAWN (1..16) + 1 CHECK cycles.
- INIT completes in at most 32 cycles after reset deasserts.

## Structure
- Package board_pkg holds:
  - Direction codes DIR_UP/DOWN/LEFT/RIGHT.
  - EXP_W=4, WIN_EXP=11, MAX_EXP=15.
  - State enum INIT/IDLE/SHIFT/SPAWN/CHECK.
  - LFSR taps.
- Sub-module line_merge, purely combinational:
  - Inputs: 4 exponents.
  - Outputs: 4 exponents, changed, score_inc[16:0].
  - Instantiated once and time-multiplexed across the 4 SHIFT cycles.

## Test plan
- Reset with SEED=16'hACE1, wait for move_ready → exactly two non-zero cells, each value 2 or 4; score 0; game_over 0.
- Load row 0 = exps [1,1,1,1], other cells empty; move left → row 0 reads 4,4,0,0; score +8; exactly one new tile.
- Load row 0 = [0,0,0,1] only; move right → board unchanged; no spawn; move_ready back high after 5 cycles.
- Load column 2 = exps [10,10,0,0]; move up → cell (0,2) reads 2048; win=1; score +2048.
- Load a full checkerboard of exps 1 and 2 → after the load, game_over=1, move_ready=0, and move_valid is ignored.
- Assert reset during SHIFT of a move → board cleared, score 0, then INIT spawns two fresh tiles.
